// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined SIMD ALU.
//   alu_op_e   : scalar operation codes (vec_op_en = 0)
//   vec_op_e   : packed-lane operation codes (vec_op_en = 1)
//   res_kind_e : how the stage-1 payload turns into a final result
//   meta_t     : tag/illegal sideband that rides alongside the result
package alu_pkg;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_PASS  = 4'd10,
    OP_MUL   = 4'd11,
    OP_RSV12 = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [3:0] {
    VOP_VADD = 4'd0,
    VOP_VSUB = 4'd1,
    VOP_VSUM = 4'd2,
    VOP_VMUL = 4'd11
  } vec_op_e;

  typedef enum logic [1:0] {
    KIND_RES,
    KIND_MUL,
    KIND_VMUL
  } res_kind_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } meta_t;

  // Number of SIMD lanes in an xlen-wide word.
  function automatic int unsigned lanes(input int unsigned xlen, input int unsigned lane_w);
    return xlen / lane_w;
  endfunction

  // Clamp a signed value into the signed range of a w-bit lane.
  function automatic logic signed [63:0] sat_lane(input logic signed [63:0] v,
                                                  input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/simd_alu_pipe_if.sv
// Request/response bundle of the pipelined ALU.
//   master : issuing side (drives the operation and out_ready)
//   slave  : the ALU (drives in_ready and the result)
interface simd_alu_pipe_if #(
  parameter int unsigned XLEN = 32
);

  logic                      in_valid;
  logic                      in_ready;
  logic [XLEN-1:0]           rs1;
  logic [XLEN-1:0]           rs2;
  logic [alu_pkg::SEL_W-1:0] alu_sel;
  logic                      vec_op_en;
  logic [alu_pkg::TAG_W-1:0] in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out;
  logic [alu_pkg::TAG_W-1:0] out_tag;
  logic                      out_illegal;

  modport master (
    output in_valid, rs1, rs2, alu_sel, vec_op_en, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, rs1, rs2, alu_sel, vec_op_en, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, out_illegal
  );

endinterface

// File: rtl/simd_lane_mul.sv
// One SIMD lane of the Q-format multiply: signed product registered on en,
// then round-half-up, arithmetic shift by VFRAC and saturate to the lane.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : capture a new product (stage-1 load)
//   a, b       : signed lane operands
//   y          : rounded, saturated lane result of the captured product
module simd_lane_mul
  import alu_pkg::*;
#(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned VFRAC  = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [LANE_W-1:0] a,
  input  logic signed [LANE_W-1:0] b,
  output logic signed [LANE_W-1:0] y
);

  // One spare bit so the rounding constant can never overflow the product.
  localparam int unsigned PW = 2 * LANE_W + 1;
  localparam logic signed [PW-1:0] RND = (VFRAC == 0) ? PW'(0) : PW'(1 << (VFRAC - 1));

  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] prod_q;
  logic signed [PW-1:0] rnd_c;
  logic signed [PW-1:0] shr_c;

  assign prod_c = PW'(a) * PW'(b);

  // Product register: splits the lane multiply from its round/saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (en) begin
      prod_q <= prod_c;
    end
  end

  assign rnd_c = prod_q + RND;
  assign shr_c = rnd_c >>> VFRAC;
  assign y     = LANE_W'(sat_lane(64'(shr_c), LANE_W));

endmodule

// File: rtl/simd_alu_pipe.sv
// Pipelined scalar/SIMD ALU for the execute stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : simd_alu_pipe_if.slave -- operation in (in_valid/in_ready,
//                rs1, rs2, alu_sel, vec_op_en, in_tag) and result out
//                (out_valid/out_ready, out, out_tag, out_illegal)
// Stage 1 resolves every non-multiply op and captures multiply partial
// products; the products are combined on the way into the next register.
// Every op takes exactly STAGES accepting edges; all stages stall together.
module simd_alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LANE_W    = 8,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned VFRAC     = 7,
  parameter int unsigned STAGES    = 2
) (
  input logic           clk,
  input logic           rst_n,
  simd_alu_pipe_if.slave bus
);

  localparam int unsigned LANES = lanes(XLEN, LANE_W);
  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned H     = XLEN / 2;
  localparam int unsigned PLW   = XLEN + H + 1;   // rs1 x unsigned low half of rs2
  localparam int unsigned PHW   = 2 * XLEN - H;   // rs1 x signed high half of rs2
  localparam int unsigned PW    = 2 * XLEN;

  logic            advance_c;
  logic            load_c;
  logic            out_valid_q;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;

  assign advance_c    = !out_valid_q || bus.out_ready;
  assign load_c       = advance_c && bus.in_valid;
  assign bus.in_ready = advance_c;
  assign rs1          = bus.rs1;
  assign rs2          = bus.rs2;

  // ---------------- stage 1 decode ----------------
  logic [XLEN-1:0] res_c;
  logic [XLEN-1:0] sum_c;
  res_kind_e       kind_c;
  logic            ill_c;
  logic [SH_W-1:0] shamt_c;

  assign shamt_c = rs2[SH_W-1:0];

  // Non-multiply results; multiplies only tag their kind here.
  always_comb begin
    res_c  = '0;
    sum_c  = rs2;
    kind_c = KIND_RES;
    ill_c  = 1'b0;
    if (!bus.vec_op_en) begin
      case (alu_op_e'(bus.alu_sel))
        OP_ADD:  res_c = rs1 + rs2;
        OP_SUB:  res_c = rs1 - rs2;
        OP_SLL:  res_c = rs1 << shamt_c;
        OP_SLT:  res_c = XLEN'($signed(rs1) < $signed(rs2));
        OP_SLTU: res_c = XLEN'(rs1 < rs2);
        OP_XOR:  res_c = rs1 ^ rs2;
        OP_SRL:  res_c = rs1 >> shamt_c;
        OP_SRA:  res_c = $unsigned($signed(rs1) >>> shamt_c);
        OP_OR:   res_c = rs1 | rs2;
        OP_AND:  res_c = rs1 & rs2;
        OP_PASS: res_c = rs2;
        OP_MUL:  kind_c = KIND_MUL;
        default: res_c = '0;
      endcase
    end else begin
      case (bus.alu_sel)
        SEL_W'(VOP_VADD): begin
          for (int i = 0; i < int'(LANES); i++) begin
            res_c[i*LANE_W +: LANE_W] = rs1[i*LANE_W +: LANE_W] + rs2[i*LANE_W +: LANE_W];
          end
        end
        SEL_W'(VOP_VSUB): begin
          for (int i = 0; i < int'(LANES); i++) begin
            res_c[i*LANE_W +: LANE_W] = rs1[i*LANE_W +: LANE_W] - rs2[i*LANE_W +: LANE_W];
          end
        end
        SEL_W'(VOP_VSUM): begin
          for (int i = 0; i < int'(LANES); i++) begin
            sum_c = sum_c + XLEN'($signed(rs1[i*LANE_W +: LANE_W]));
          end
          res_c = sum_c;
        end
        SEL_W'(VOP_VMUL): kind_c = KIND_VMUL;
        default:          ill_c  = 1'b1;
      endcase
    end
  end

  // Scalar multiply split on rs2 halves so each partial product stays narrow.
  logic signed [XLEN-1:0]   mul_a_c;
  logic signed [H:0]        mul_blo_c;
  logic signed [XLEN-H-1:0] mul_bhi_c;
  logic signed [PLW-1:0]    pp_lo_c;
  logic signed [PHW-1:0]    pp_hi_c;

  assign mul_a_c   = $signed(rs1);
  assign mul_blo_c = $signed({1'b0, rs2[H-1:0]});
  assign mul_bhi_c = $signed(rs2[XLEN-1:H]);
  assign pp_lo_c   = PLW'(mul_a_c) * PLW'(mul_blo_c);
  assign pp_hi_c   = PHW'(mul_a_c) * PHW'(mul_bhi_c);

  // ---------------- stage 1 registers ----------------
  logic                  s1_valid;
  meta_t                 s1_meta;
  res_kind_e             s1_kind;
  logic [XLEN-1:0]       s1_res;
  logic signed [PLW-1:0] s1_pp_lo;
  logic signed [PHW-1:0] s1_pp_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_meta  <= '0;
      s1_kind  <= KIND_RES;
      s1_res   <= '0;
      s1_pp_lo <= '0;
      s1_pp_hi <= '0;
    end else begin
      if (advance_c) begin
        s1_valid <= bus.in_valid;
      end
      if (load_c) begin
        s1_meta  <= '{tag: bus.in_tag, illegal: ill_c};
        s1_kind  <= kind_c;
        s1_res   <= res_c;
        s1_pp_lo <= pp_lo_c;
        s1_pp_hi <= pp_hi_c;
      end
    end
  end

  // Lane multipliers keep their own product register inside stage 1.
  logic [XLEN-1:0] vmul_y;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    simd_lane_mul #(
      .LANE_W(LANE_W),
      .VFRAC (VFRAC)
    ) u_lane_mul (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (load_c),
      .a    (rs1[l*LANE_W +: LANE_W]),
      .b    (rs2[l*LANE_W +: LANE_W]),
      .y    (vmul_y[l*LANE_W +: LANE_W])
    );
  end

  // Finish the multiplies and pick the stage-1 result.
  logic signed [PW-1:0] prod_c;
  logic [XLEN-1:0]      mul_res_c;
  logic [XLEN-1:0]      s1_final_c;

  assign prod_c    = PW'(s1_pp_lo) + (PW'(s1_pp_hi) <<< H);
  assign mul_res_c = XLEN'(prod_c >> FRAC_BITS);

  always_comb begin
    s1_final_c = s1_res;
    case (s1_kind)
      KIND_MUL:  s1_final_c = mul_res_c;
      KIND_VMUL: s1_final_c = vmul_y;
      default:   s1_final_c = s1_res;
    endcase
  end

  // ---------------- remaining stages ----------------
  meta_t           out_meta;
  logic [XLEN-1:0] out_res;

  if (STAGES > 1) begin : g_tail
    localparam int TN = int'(STAGES) - 1;

    logic            t_valid [TN];
    meta_t           t_meta  [TN];
    logic [XLEN-1:0] t_res   [TN];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < TN; i++) begin
          t_valid[i] <= 1'b0;
          t_meta[i]  <= '0;
          t_res[i]   <= '0;
        end
      end else if (advance_c) begin
        t_valid[0] <= s1_valid;
        t_meta[0]  <= s1_meta;
        t_res[0]   <= s1_final_c;
        for (int i = 1; i < TN; i++) begin
          t_valid[i] <= t_valid[i-1];
          t_meta[i]  <= t_meta[i-1];
          t_res[i]   <= t_res[i-1];
        end
      end
    end

    assign out_valid_q = t_valid[TN-1];
    assign out_meta    = t_meta[TN-1];
    assign out_res     = t_res[TN-1];
  end else begin : g_direct
    assign out_valid_q = s1_valid;
    assign out_meta    = s1_meta;
    assign out_res     = s1_final_c;
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out         = out_res;
  assign bus.out_tag     = out_meta.tag;
  assign bus.out_illegal = out_meta.illegal;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe (XLEN=32, LANE_W=8, FRAC_BITS=16,
// VFRAC=7, STAGES=2). The driver pushes expected results when an op is
// accepted; the monitor compares every presented output with the head.
module tb_simd_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  simd_alu_pipe_if #(.XLEN(XLEN)) bus ();

  simd_alu_pipe #(
    .XLEN     (32),
    .LANE_W   (8),
    .FRAC_BITS(16),
    .VFRAC    (7),
    .STAGES   (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  sel;
    logic        vec;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] eres;
    logic        eill;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t sbq [$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;

  // Reference behaviour computed with plain integer arithmetic.
  function automatic op_t with_model(input op_t o);
    logic [31:0] a, b, r;
    longint      p;
    int          x, y, s, acc;
    a = o.a;
    b = o.b;
    r = '0;
    o.eill = 1'b0;
    if (!o.vec) begin
      case (o.sel)
        4'd0:  r = a + b;
        4'd1:  r = a - b;
        4'd2:  r = a << b[4:0];
        4'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'd4:  r = (a < b) ? 32'd1 : 32'd0;
        4'd5:  r = a ^ b;
        4'd6:  r = a >> b[4:0];
        4'd7:  r = $signed(a) >>> b[4:0];
        4'd8:  r = a | b;
        4'd9:  r = a & b;
        4'd10: r = b;
        4'd11: begin
          p = longint'($signed(a)) * longint'($signed(b));
          r = 32'(p >>> 16);
        end
        default: r = '0;
      endcase
    end else begin
      case (o.sel)
        4'd0, 4'd1, 4'd11: begin
          for (int i = 0; i < 4; i++) begin
            x = int'($signed(a[8*i +: 8]));
            y = int'($signed(b[8*i +: 8]));
            if (o.sel == 4'd0) s = x + y;
            else if (o.sel == 4'd1) s = x - y;
            else begin
              s = (x * y + 64) >>> 7;
              if (s > 127) s = 127;
              if (s < -128) s = -128;
            end
            r[8*i +: 8] = 8'(s);
          end
        end
        4'd2: begin
          acc = $signed(b);
          for (int i = 0; i < 4; i++) acc += int'($signed(a[8*i +: 8]));
          r = 32'(acc);
        end
        default: begin
          r = '0;
          o.eill = 1'b1;
        end
      endcase
    end
    o.eres = r;
    return o;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 11))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8080_8080;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t gen_op();
    op_t o;
    o.vec = 1'($urandom_range(0, 1));
    if (o.vec) begin
      case ($urandom_range(0, 9))
        0, 1:    o.sel = 4'd0;
        2, 3:    o.sel = 4'd1;
        4, 5:    o.sel = 4'd2;
        6, 7:    o.sel = 4'd11;
        default: o.sel = 4'($urandom_range(0, 15));
      endcase
    end else begin
      o.sel = 4'($urandom_range(0, 15));
    end
    o.a   = rnd_word();
    o.b   = rnd_word();
    o.tag = 5'($urandom_range(0, 31));
    return with_model(o);
  endfunction

  function automatic op_t mk(input logic [3:0] sel, input logic vec, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] tag,
                             input logic [31:0] eres, input logic eill);
    op_t o;
    o.sel = sel; o.vec = vec; o.a = a; o.b = b; o.tag = tag; o.eres = eres; o.eill = eill;
    return o;
  endfunction

  task automatic apply(input op_t o);
    bus.in_valid  = 1'b1;
    bus.alu_sel   = o.sel;
    bus.vec_op_en = o.vec;
    bus.rs1       = o.a;
    bus.rs2       = o.b;
    bus.in_tag    = o.tag;
  endtask

  task automatic push_exp(input op_t o);
    exp_t e;
    e.res = o.eres;
    e.tag = o.tag;
    e.ill = o.eill;
    sbq.push_back(e);
  endtask

  // Present an op each cycle until it is accepted (bounded).
  task automatic issue(input op_t o);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      apply(o);
      #1;
      if (bus.in_ready) begin
        push_exp(o);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus.out_valid) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL spurious_out: got out=%h tag=%0d with no result required",
                 bus.out, bus.out_tag);
      end else begin
        e = sbq[0];
        if (bus.out !== e.res || bus.out_tag !== e.tag || bus.out_illegal !== e.ill) begin
          n_err++;
          $display("FAIL result: got out=%h tag=%0d ill=%b required out=%h tag=%0d ill=%b",
                   bus.out, bus.out_tag, bus.out_illegal, e.res, e.tag, e.ill);
        end
        if (bus.out_ready) void'(sbq.pop_front());
      end
    end
  end

  op_t dirs [$];
  int  acc_n;

  initial begin
    bus.in_valid  = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.alu_sel   = '0;
    bus.vec_op_en = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    #3;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out", bus.out, 32'd0);
    chk("reset_out_tag", 32'(bus.out_tag), 32'd0);
    chk("reset_out_illegal", 32'(bus.out_illegal), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    #20 rst_n = 1'b1;

    // Latency: result visible after exactly two edges including the accept edge.
    issue(mk(4'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, 32'h0, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("latency_edge1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #1 chk("latency_edge2_valid", 32'(bus.out_valid), 32'd1);
    drain();

    // Directed vectors, back to back.
    dirs.push_back(mk(4'd11, 1'b0, 32'h0003_0000, 32'h0002_0000, 5'd1, 32'h0006_0000, 1'b0));
    dirs.push_back(mk(4'd11, 1'b0, 32'hFFFF_0000, 32'h0002_0000, 5'd2, 32'hFFFE_0000, 1'b0));
    dirs.push_back(mk(4'd11, 1'b1, 32'h8080_4040, 32'h8080_4040, 5'd3, 32'h7F7F_2020, 1'b0));
    dirs.push_back(mk(4'd2,  1'b1, 32'hFF01_0203, 32'h0000_000A, 5'd4, 32'h0000_000F, 1'b0));
    dirs.push_back(mk(4'd0,  1'b1, 32'h7F7F_7F7F, 32'h0101_0101, 5'd5, 32'h8080_8080, 1'b0));
    dirs.push_back(mk(4'd5,  1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6, 32'h0000_0000, 1'b1));
    dirs.push_back(mk(4'd7,  1'b0, 32'h8000_0000, 32'h0000_0004, 5'd7, 32'hF800_0000, 1'b0));
    dirs.push_back(mk(4'd2,  1'b0, 32'h0000_0001, 32'h0000_003F, 5'd8, 32'h8000_0000, 1'b0));
    dirs.push_back(mk(4'd3,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 32'h0000_0001, 1'b0));
    dirs.push_back(mk(4'd4,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd11, 32'h0000_0000, 1'b0));
    dirs.push_back(mk(4'd1,  1'b0, 32'h0000_0000, 32'h0000_0001, 5'd12, 32'hFFFF_FFFF, 1'b0));
    dirs.push_back(mk(4'd13, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd13, 32'h0000_0000, 1'b0));
    dirs.push_back(mk(4'd1,  1'b1, 32'h8000_0001, 32'h0100_0002, 5'd14, 32'h7F00_00FF, 1'b0));
    dirs.push_back(mk(4'd10, 1'b0, 32'h1111_1111, 32'hCAFE_F00D, 5'd31, 32'hCAFE_F00D, 1'b0));
    foreach (dirs[i]) issue(dirs[i]);
    idle(1);
    drain();

    // Stall: consumer holds off for six cycles while ops keep arriving.
    bus.out_ready = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 6; c++) begin
      op_t o;
      o = gen_op();
      @(negedge clk);
      apply(o);
      #1;
      if (bus.in_ready) begin
        push_exp(o);
        acc_n++;
      end
    end
    chk("stall_accepts", 32'(acc_n), 32'd2);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) issue(gen_op());
    idle(1);
    drain();

    // Asynchronous reset with two ops in flight.
    bus.out_ready = 1'b0;
    issue(gen_op());
    issue(gen_op());
    @(posedge clk);
    #3;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out", bus.out, 32'd0);
    sbq.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 chk("postrst_idle_valid", 32'(bus.out_valid), 32'd0);
    end
    issue(mk(4'd0, 1'b0, 32'h0000_0005, 32'h0000_0007, 5'd17, 32'h0000_000C, 1'b0));
    idle(1);
    drain();

    // Random traffic with random back-pressure and bubbles.
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      issue(gen_op());
    end
    rand_ready = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
